// File: rtl/rr_mux_arbiter_pkg.sv
// Purpose: shared definitions for the round-robin mux arbiter (state encoding, sizes, one-hot helper).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rr_mux_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        TURN  = 2'b10
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Purpose: rotate-priority picker; returns the first requester at or after ptr (mod 4).
// Latency: combinational.
// Backpressure: n/a.
// Ports: req - request vector; ptr - highest-priority index;
//        idx - picked index (0 when none); any - at least one request present.
module rr_pick
    import rr_mux_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down to ptr itself so the nearest
    // requester (smallest offset) is the last, and therefore winning, write.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Purpose: round-robin owner selection for a shared 4:1 mux, with bounded hold and a one-cycle turnaround.
// Latency: 1 cycle from req sampled to gnt/sel/valid; 2 edges between consecutive owners.
// Backpressure: requesters hold req until served; an owner is forced off after HOLD_MAX cycles if others wait.
// Ports: clk, rst (async active-high); req[3:0] in; gnt[3:0] one-hot grant, sel[1:0] mux select,
//        valid (gnt non-zero), preempt (pulse in a TURN cycle caused by forced rotation) - all registered.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 4
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic       preempt
);

    localparam int               CNT_W    = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             owner_rel;
    logic             others_wait;
    logic             force_rot;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // In GRANT, sel is the owner index.
    assign owner_rel   = ~req[sel];
    assign others_wait = |(req & ~onehot(sel));
    assign force_rot   = (hold_cnt == HOLD_LIM) && others_wait;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            sel      <= '0;
            valid    <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            case (state)
                IDLE, TURN: begin
                    preempt <= 1'b0;
                    if (pick_any) begin
                        state    <= GRANT;
                        gnt      <= onehot(pick_idx);
                        sel      <= pick_idx;
                        valid    <= 1'b1;
                        hold_cnt <= CNT_W'(1);
                    end else begin
                        state <= IDLE;
                        gnt   <= '0;
                        valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (owner_rel || force_rot) begin
                        // Owner moves to lowest priority; sel keeps the old
                        // owner so the mux stays stable through the turnaround.
                        state    <= TURN;
                        ptr      <= sel + IDX_W'(1);
                        gnt      <= '0;
                        valid    <= 1'b0;
                        hold_cnt <= '0;
                        preempt  <= ~owner_rel;
                    end else if (hold_cnt != HOLD_LIM) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    gnt      <= '0;
                    valid    <= 1'b0;
                    preempt  <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Purpose: self-checking bench for rr_mux_arbiter (directed scenarios plus randomized run against a reference model).
// Latency: n/a.
// Backpressure: n/a.
module tb_rr_mux_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       preempt;

    int n_cmp = 0;
    int n_err = 0;

    rr_mux_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .valid   (valid),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (integer bookkeeping) ----------------
    int m_owner;    // -1 when nobody owns the resource
    bit m_gap;      // the turnaround cycle is in progress
    int m_ptr;
    int m_hold;
    bit m_pre;
    int m_sel;

    function automatic int first_from(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_gap = 0; m_ptr = 0; m_hold = 0; m_pre = 0; m_sel = 0;
    endtask

    // Advance the model by one clock edge with request vector r.
    task automatic model_step(input logic [3:0] r);
        int p;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_ptr = (m_owner + 1) % 4; m_owner = -1; m_gap = 1; m_pre = 0;
            end else if (m_hold == HOLD && (r & ~(4'b0001 << m_owner)) != 4'b0000) begin
                m_ptr = (m_owner + 1) % 4; m_owner = -1; m_gap = 1; m_pre = 1;
            end else begin
                m_hold = (m_hold < HOLD) ? m_hold + 1 : HOLD;
            end
        end else begin
            m_gap = 0;
            m_pre = 0;
            p = first_from(r, m_ptr);
            if (p >= 0) begin
                m_owner = p; m_sel = p; m_hold = 1;
            end
        end
    endtask

    function automatic logic [3:0] model_gnt();
        return (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        #3;
        rst = 1'b0;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        req = 4'b1111;
        @(negedge clk);
        rst = 1'b1;
        #2;
        n_cmp++;
        if (gnt !== 4'b0000 || sel !== 2'b00 || valid !== 1'b0 || preempt !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: gnt=%b sel=%0d valid=%b preempt=%b, want 0000/0/0/0", gnt, sel, valid, preempt);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001 || sel !== 2'd0 || valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first_grant: gnt=%b sel=%0d valid=%b, want 0001/0/1", gnt, sel, valid);
        end
        do_reset();
    endtask

    task automatic test_single();
        req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (gnt !== 4'b0100 || sel !== 2'd2 || valid !== 1'b1) begin
                n_err++;
                $display("FAIL single_hold[%0d]: gnt=%b sel=%0d valid=%b, want 0100/2/1", c, gnt, sel, valid);
            end
        end
        req = 4'b0000;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000 || valid !== 1'b0 || sel !== 2'd2 || preempt !== 1'b0) begin
            n_err++;
            $display("FAIL single_turn: gnt=%b valid=%b sel=%0d preempt=%b, want 0000/0/2/0", gnt, valid, sel, preempt);
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b0000 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: gnt=%b valid=%b, want 0000/0", gnt, valid);
        end
        req = 4'b1001;
        tick();
        n_cmp++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            n_err++;
            $display("FAIL single_ptr: gnt=%b sel=%0d, want 1000/3", gnt, sel);
        end
        do_reset();
    endtask

    task automatic test_rotation();
        logic [3:0] exp;
        req = 4'b1111;
        for (int o = 0; o < 4; o++) begin
            exp = 4'b0001 << o;
            for (int c = 0; c < HOLD; c++) begin
                tick();
                n_cmp++;
                if (gnt !== exp || preempt !== 1'b0) begin
                    n_err++;
                    $display("FAIL rotation_owner%0d[%0d]: gnt=%b preempt=%b, want %b/0", o, c, gnt, preempt, exp);
                end
            end
            tick();
            n_cmp++;
            if (gnt !== 4'b0000 || preempt !== 1'b1 || valid !== 1'b0) begin
                n_err++;
                $display("FAIL rotation_turn%0d: gnt=%b preempt=%b valid=%b, want 0000/1/0", o, gnt, preempt, valid);
            end
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b0001 || preempt !== 1'b0) begin
            n_err++;
            $display("FAIL rotation_wrap: gnt=%b preempt=%b, want 0001/0", gnt, preempt);
        end
        do_reset();
    endtask

    task automatic test_lone();
        int bad;
        bad = 0;
        req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (gnt !== 4'b0001 || preempt !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL lone_hold: %0d cycles off, want 0 (last gnt=%b preempt=%b)", bad, gnt, preempt);
        end
        n_cmp++;
        if (dut.hold_cnt !== 3'(HOLD)) begin
            n_err++;
            $display("FAIL lone_saturate: hold_cnt=%0d, want %0d", dut.hold_cnt, HOLD);
        end
        do_reset();
    endtask

    task automatic test_async_reset();
        req = 4'b0100;
        tick();
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_err++;
            $display("FAIL areset_pre: gnt=%b, want 0100", gnt);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 4'b0000 || valid !== 1'b0 || preempt !== 1'b0) begin
            n_err++;
            $display("FAIL areset_drop: gnt=%b valid=%b preempt=%b, want 0000/0/0", gnt, valid, preempt);
        end
        req = 4'b0110;
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++;
        if (gnt !== 4'b0010 || sel !== 2'd1) begin
            n_err++;
            $display("FAIL areset_after: gnt=%b sel=%0d, want 0010/1", gnt, sel);
        end
        do_reset();
    endtask

    task automatic test_release_new();
        req = 4'b0010;
        tick();
        req = 4'b1001;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000 || preempt !== 1'b0 || sel !== 2'd1) begin
            n_err++;
            $display("FAIL relnew_turn: gnt=%b preempt=%b sel=%0d, want 0000/0/1", gnt, preempt, sel);
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            n_err++;
            $display("FAIL relnew_grant: gnt=%b sel=%0d, want 1000/3", gnt, sel);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [3:0] eg;
        model_reset();
        r = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            // Each bit flips with probability 1/4 so ownership lasts long enough to hit preemption.
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            end
            req = r;
            model_step(r);
            tick();
            eg = model_gnt();
            n_cmp++;
            if (gnt !== eg || sel !== 2'(m_sel) || valid !== (eg != 4'b0000) || preempt !== m_pre) begin
                n_err++;
                $display("FAIL random[%0d] req=%b: gnt=%b sel=%0d valid=%b preempt=%b, want %b/%0d/%b/%b",
                         c, r, gnt, sel, valid, preempt, eg, m_sel, (eg != 4'b0000), m_pre);
            end
            n_cmp++;
            if ($countones(gnt) > 1 || valid !== (|gnt) || (valid && gnt !== (4'b0001 << sel))) begin
                n_err++;
                $display("FAIL invariant[%0d]: gnt=%b sel=%0d valid=%b, want onehot0 and consistent", c, gnt, sel, valid);
            end
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_lone();
        test_async_reset();
        test_release_new();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
